// File: rtl/sram_pkg.sv
// Shared widths and FSM state encoding for the asynchronous SRAM controller.
package sram_pkg;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WAIT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_WAIT,
        ST_RD_LATCH
    } state_t;
endpackage

// File: rtl/sram_ctrl.sv
// Single-port async SRAM controller: write = 2+WE_PULSE cycles, read response RD_WAIT+2 cycles after accept.
// One request in flight; req_ready is high only in IDLE, so the host stalls while a cycle is running.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int RD_WAIT  = 2,
    parameter int WE_PULSE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [SRAM_ADDR_W-1:0] req_addr,
    input  logic [SRAM_DATA_W-1:0] req_wdata,
    output logic                   rsp_valid,
    output logic [SRAM_DATA_W-1:0] rsp_rdata,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    inout  wire  [SRAM_DATA_W-1:0] sram_data,
    output logic                   sram_cs,
    output logic                   sram_oe,
    output logic                   sram_we,
    output logic                   busy
);

    if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
        $error("sram_ctrl: RD_WAIT must be in 1..15");
    end
    if (WE_PULSE < 1 || WE_PULSE > 15) begin : g_bad_we_pulse
        $error("sram_ctrl: WE_PULSE must be in 1..15");
    end

    localparam logic [WAIT_W-1:0] RD_LOAD = WAIT_W'(RD_WAIT - 1);
    localparam logic [WAIT_W-1:0] WP_LOAD = WAIT_W'(WE_PULSE - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [WAIT_W-1:0]      r_cnt;
    logic [WAIT_W-1:0]      w_cnt_nxt;
    logic                   w_accept;
    logic                   w_cs_n_nxt;
    logic                   w_oe_n_nxt;
    logic                   w_we_n_nxt;
    logic                   w_drv_nxt;

    logic [SRAM_ADDR_W-1:0] r_addr;
    logic [SRAM_DATA_W-1:0] r_wdata;
    logic [SRAM_DATA_W-1:0] r_cap;
    logic [SRAM_DATA_W-1:0] r_rdata;
    logic                   r_rsp_vld;
    logic                   r_cs_n;
    logic                   r_oe_n;
    logic                   r_we_n;
    logic                   r_drv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pin controls are decoded from the next state and registered, so they
    // line up with the state they belong to and never see request inputs directly.
    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (req_we) begin
                        w_next = ST_WR_SETUP;
                    end else begin
                        w_next    = ST_RD_WAIT;
                        w_cnt_nxt = RD_LOAD;
                    end
                end
            end
            ST_WR_SETUP: begin
                w_next    = ST_WR_PULSE;
                w_cnt_nxt = WP_LOAD;
            end
            ST_WR_PULSE: begin
                if (r_cnt == '0) w_next = ST_WR_HOLD;
                else             w_cnt_nxt = r_cnt - 1'b1;
            end
            ST_WR_HOLD:  w_next = ST_IDLE;
            ST_RD_WAIT: begin
                if (r_cnt == '0) w_next = ST_RD_LATCH;
                else             w_cnt_nxt = r_cnt - 1'b1;
            end
            ST_RD_LATCH: w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase

        w_cs_n_nxt = (w_next == ST_IDLE);
        w_oe_n_nxt = (w_next != ST_RD_WAIT);
        w_we_n_nxt = (w_next != ST_WR_PULSE);
        w_drv_nxt  = (w_next == ST_WR_SETUP) || (w_next == ST_WR_PULSE) ||
                     (w_next == ST_WR_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cap     <= '0;
            r_rdata   <= '0;
            r_rsp_vld <= 1'b0;
            r_cs_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_drv     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= req_addr;
                if (req_we) r_wdata <= req_wdata;
            end
            // Sample the bus on the last OE-low edge; RD_LATCH has OE high again.
            if (r_state == ST_RD_WAIT && w_next == ST_RD_LATCH) r_cap <= sram_data;
            if (r_state == ST_RD_LATCH) r_rdata <= r_cap;
            r_rsp_vld <= (r_state == ST_RD_LATCH);
            r_cs_n    <= w_cs_n_nxt;
            r_oe_n    <= w_oe_n_nxt;
            r_we_n    <= w_we_n_nxt;
            r_drv     <= w_drv_nxt;
        end
    end

    assign sram_data = r_drv ? r_wdata : {SRAM_DATA_W{1'bz}};
    assign sram_addr = r_addr;
    assign sram_cs   = r_cs_n;
    assign sram_oe   = r_oe_n;
    assign sram_we   = r_we_n;
    assign rsp_valid = r_rsp_vld;
    assign rsp_rdata = r_rdata;
    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl against an async SRAM model and a word-level memory reference.
`timescale 1ns/1ps
module tb_sram_ctrl;
    import sram_pkg::*;

    localparam int P_RD_WAIT  = 2;
    localparam int P_WE_PULSE = 1;
    localparam int MEM_WORDS  = 1 << SRAM_ADDR_W;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   req_valid = 1'b0;
    logic                   req_we = 1'b0;
    logic [SRAM_ADDR_W-1:0] req_addr = '0;
    logic [SRAM_DATA_W-1:0] req_wdata = '0;
    logic                   req_ready;
    logic                   rsp_valid;
    logic [SRAM_DATA_W-1:0] rsp_rdata;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    wire  [SRAM_DATA_W-1:0] sram_data;
    logic                   sram_cs;
    logic                   sram_oe;
    logic                   sram_we;
    logic                   busy;

    sram_ctrl #(.RD_WAIT(P_RD_WAIT), .WE_PULSE(P_WE_PULSE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we), .busy(busy)
    );

    always #5 clk = ~clk;

    // Async SRAM device: drives the bus while selected with OE low, writes on WE rising.
    logic [SRAM_DATA_W-1:0] dev_mem [0:MEM_WORDS-1];
    assign sram_data = (!sram_cs && !sram_oe) ? dev_mem[sram_addr] : {SRAM_DATA_W{1'bz}};
    always @(posedge sram_we) begin
        if (!sram_cs && rst_n) dev_mem[sram_addr] <= sram_data;
    end

    // Reference: what every address should hold after the writes issued so far.
    logic [SRAM_DATA_W-1:0] ref_mem [logic [SRAM_ADDR_W-1:0]];
    logic [SRAM_DATA_W-1:0] last_rsp = '0;

    function automatic logic [SRAM_DATA_W-1:0] exp_rd(input logic [SRAM_ADDR_W-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return '0;
    endfunction

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    int op_acc_wait, cyc_cs, cyc_we, cyc_oe, cyc_busy, both_low;
    int addr_bad, data_bad, hold_bad, rsp_cnt, rsp_at;
    logic [SRAM_DATA_W-1:0] rsp_seen;

    // Called at a negedge; presents the request, observes every cycle until IDLE, then checks.
    task automatic do_op(input logic we, input logic [SRAM_ADDR_W-1:0] a,
                         input logic [SRAM_DATA_W-1:0] d, input bit scramble, input bit chk_data);
        bit acc  = 1'b0;
        bit done = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        op_acc_wait = 0;
        while (!acc && op_acc_wait < 20) begin
            if (req_ready) acc = 1'b1;
            else begin @(negedge clk); op_acc_wait++; end
        end
        if (!acc) begin
            req_valid = 1'b0;
            chk("accept_timeout", 32'(op_acc_wait), 32'd0);
            return;
        end
        cyc_cs = 0; cyc_we = 0; cyc_oe = 0; cyc_busy = 0; both_low = 0;
        addr_bad = 0; data_bad = 0; hold_bad = 0; rsp_cnt = 0; rsp_at = 0; rsp_seen = '0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (!sram_cs) cyc_cs++;
            if (!sram_we) cyc_we++;
            if (!sram_oe) cyc_oe++;
            if (busy)     cyc_busy++;
            if (!sram_we && !sram_oe) both_low++;
            if (!sram_cs && sram_addr != a) addr_bad++;
            if (we && !sram_cs && sram_data != d) data_bad++;
            if (we && rsp_rdata != last_rsp) hold_bad++;
            if (rsp_valid) begin rsp_cnt++; rsp_at = k; rsp_seen = rsp_rdata; end
            if (!busy) done = 1'b1;
            else if (scramble) begin
                req_valid = 1'($urandom); req_we = 1'($urandom);
                req_addr = 18'($urandom); req_wdata = 16'($urandom);
            end else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        if (!done) begin
            chk("op_timeout", 32'(done), 32'd1);
            return;
        end
        if (we) begin
            chk("wr_cs_cycles", 32'(cyc_cs), 32'(2 + P_WE_PULSE));
            chk("wr_we_cycles", 32'(cyc_we), 32'(P_WE_PULSE));
            chk("wr_oe_cycles", 32'(cyc_oe), 32'd0);
            chk("wr_no_rsp", 32'(rsp_cnt), 32'd0);
            chk("wr_data_stable", 32'(data_bad), 32'd0);
            chk("wr_rdata_hold", 32'(hold_bad), 32'd0);
            ref_mem[a] = d;
        end else begin
            chk("rd_cs_cycles", 32'(cyc_cs), 32'(P_RD_WAIT + 1));
            chk("rd_oe_cycles", 32'(cyc_oe), 32'(P_RD_WAIT));
            chk("rd_we_cycles", 32'(cyc_we), 32'd0);
            chk("rd_rsp_count", 32'(rsp_cnt), 32'd1);
            chk("rd_latency", 32'(rsp_at), 32'(P_RD_WAIT + 2));
            if (chk_data) chk("rd_data", 32'(rsp_seen), 32'(exp_rd(a)));
            last_rsp = rsp_seen;
        end
        chk("addr_stable", 32'(addr_bad), 32'd0);
        chk("oe_we_overlap", 32'(both_low), 32'd0);
        chk("busy_cycles", 32'(cyc_busy), we ? 32'(2 + P_WE_PULSE) : 32'(P_RD_WAIT + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SRAM_ADDR_W-1:0] a;
        for (int i = 0; i < MEM_WORDS; i++) dev_mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_we", 32'(sram_we), 32'd1);
        chk("rst_oe", 32'(sram_oe), 32'd1);
        chk("rst_cs", 32'(sram_cs), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        do_op(1'b1, 18'h00005, 16'hA5A5, 1'b0, 1'b1);
        chk("first_accept_wait", 32'(op_acc_wait), 32'd0);
        do_op(1'b0, 18'h00005, 16'h0000, 1'b0, 1'b1);
        chk("rd_a5a5", 32'(rsp_seen), 32'h0000A5A5);

        // Read immediately followed by write, request held high throughout.
        do_op(1'b0, 18'h00005, 16'h0000, 1'b1, 1'b1);
        do_op(1'b1, 18'h00006, 16'h5A5A, 1'b1, 1'b1);
        chk("b2b_turnaround", 32'(op_acc_wait), 32'd0);

        do_op(1'b1, 18'h3FFFF, 16'hFFFF, 1'b0, 1'b1);
        do_op(1'b1, 18'h00000, 16'h0000, 1'b0, 1'b1);
        do_op(1'b0, 18'h3FFFF, 16'h0000, 1'b0, 1'b1);
        chk("rd_top_addr", 32'(rsp_seen), 32'h0000FFFF);
        do_op(1'b0, 18'h00000, 16'h0000, 1'b0, 1'b1);
        chk("rd_zero_addr", 32'(rsp_seen), 32'h00000000);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0:       a = 18'h3FFFF;
                1:       a = 18'h00000;
                default: a = 18'($urandom_range(0, 47));
            endcase
            do_op(1'($urandom), a, 16'($urandom), 1'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Reset during the WE pulse of a write must abort it asynchronously.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h00123; req_wdata = 16'h1234;
        chk("abort_pre_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_pre_we_low", 32'(sram_we), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(sram_we), 32'd1);
        chk("abort_cs", 32'(sram_cs), 32'd1);
        chk("abort_oe", 32'(sram_oe), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("abort_rdata_clr", 32'(rsp_rdata), 32'd0);
        chk("abort_addr_clr", 32'(sram_addr), 32'd0);
        last_rsp = '0;
        rst_n = 1'b1;
        do_op(1'b0, 18'h00123, 16'h0000, 1'b0, 1'b0);
        chk("post_rst_accept_wait", 32'(op_acc_wait), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
